// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Index-width helper keeps the counter at least one bit wide for a single-nibble build.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    localparam int NIBBLE_W = 4;

    function automatic int nsa_idx_w(input int width);
        int nib;
        nib = width / NIBBLE_W;
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/rca.sv
// Existing 4-bit ripple-carry adder: sum = a + b + cin, cout = carry out of bit 3.
module rca (
    input  logic       cin,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder feeding one nibble per cycle through the shared 4-bit rca.
// Optional signed-overflow output enabled by defining OVERFLOW_FLAG_EN.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for an operand handshake
//   RUN   | one nibble per cycle through rca, carry chained via a register
//   DONE  | result held with out_valid high until out_ready
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = nsa_idx_w(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    nsa_state_t          state;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic                carry;
    logic [IDX_W-1:0]    idx;
    logic [NIBBLE_W-1:0] sum_nib [NIB];

    logic [NIBBLE_W-1:0] a_nib [NIB];
    logic [NIBBLE_W-1:0] b_nib [NIB];
    logic [NIBBLE_W-1:0] rca_sum;
    logic                rca_cout;

    for (genvar g = 0; g < NIB; g++) begin : g_nib
        assign a_nib[g] = a_reg[g*NIBBLE_W +: NIBBLE_W];
        assign b_nib[g] = b_reg[g*NIBBLE_W +: NIBBLE_W];
        assign sum[g*NIBBLE_W +: NIBBLE_W] = sum_nib[g];
    end

    // cin is loaded into the carry register on accept, so nibble 0 needs no special case.
    rca u_rca (
        .cin  (carry),
        .a    (a_nib[idx]),
        .b    (b_nib[idx]),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            cout      <= 1'b0;
            for (int i = 0; i < NIB; i++) sum_nib[i] <= '0;
`ifdef OVERFLOW_FLAG_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        carry    <= cin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_nib[idx] <= rca_sum;
                    carry        <= rca_cout;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        cout      <= rca_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef OVERFLOW_FLAG_EN
                        ovf <= (a_reg[WIDTH-1] ~^ b_reg[WIDTH-1])
                             & (a_reg[WIDTH-1] ^ rca_sum[NIBBLE_W-1]);
`endif
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
